// File: rtl/codec_pkg.sv
// codec_pkg: shared constants and types for the whole-frame transform/quantize engine.
//   IMG_H_DEF/IMG_W_DEF : default frame size (rows multiple of 8, columns multiple of 16)
//   BLK / BLK_PIX       : block edge and pixel count per block
//   pixel_t / coeff_t   : signed 9-bit pixel, signed 54-bit coefficient
//   DCT_C               : 8x8 integer DCT-II basis, scaled by 4096 and rounded half away from zero
//   QSHIFT              : extra per-frequency right shift applied on top of BASE_SHIFT
//   state_t             : controller FSM encoding
package codec_pkg;

    localparam int IMG_H_DEF  = 480;
    localparam int IMG_W_DEF  = 640;
    localparam int BLK        = 8;
    localparam int BLK_PIX    = BLK * BLK;
    localparam int PIX_W      = 9;
    localparam int COEFF_W    = 54;
    // Removes the 4096*4096 scaling of the two basis multiplications.
    localparam int BASE_SHIFT = 24;

    typedef logic signed [PIX_W-1:0]   pixel_t;
    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Row k is frequency k, column n is sample n. Every row k>0 sums to
    // zero, which makes all AC terms of a flat block exactly zero.
    localparam logic signed [12:0] DCT_C [BLK][BLK] = '{
        '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
        '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,  -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
        '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892, -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
        '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,  13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
        '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
        '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703, -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
        '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,  -13'sd784,   13'sd1892, -13'sd1892,  13'sd784 },
        '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,  13'sd2009, -13'sd1703,  13'sd1138, -13'sd400 }
    };

    // 4 + ((u+v) >> 1): coarser quantization toward high frequencies.
    localparam int QSHIFT [BLK][BLK] = '{
        '{4, 4, 5, 5, 6, 6, 7, 7},
        '{4, 5, 5, 6, 6, 7, 7, 8},
        '{5, 5, 6, 6, 7, 7, 8, 8},
        '{5, 6, 6, 7, 7, 8, 8, 9},
        '{6, 6, 7, 7, 8, 8, 9, 9},
        '{6, 7, 7, 8, 8, 9, 9, 10},
        '{7, 7, 8, 8, 9, 9, 10, 10},
        '{7, 8, 8, 9, 9, 10, 10, 11}
    };

endpackage

// File: rtl/dct8x8_quant.sv
// dct8x8_quant: combinational 8x8 integer 2-D DCT-II followed by shift quantization.
//   pix   : 64 signed 9-bit pixels, index r*8+c (row r, column c)
//   coeff : 64 signed 54-bit coefficients, index u*8+v,
//           coeff(u,v) = (C*X*C^T)(u,v) >>> (BASE_SHIFT + QSHIFT[u][v])
// The intermediate C*X fits in 25 bits and C*X*C^T in 41 bits, so the
// 32-bit and 54-bit accumulators are exact.
module dct8x8_quant
    import codec_pkg::*;
(
    input  logic signed [PIX_W-1:0]   pix   [BLK_PIX],
    output logic signed [COEFF_W-1:0] coeff [BLK_PIX]
);

    logic signed [31:0]        t_acc;
    logic signed [31:0]        t_mat [BLK][BLK];
    logic signed [COEFF_W-1:0] y_acc;
    logic signed [COEFF_W-1:0] y_mat [BLK][BLK];

    // Column pass: T = C * X
    always_comb begin
        t_acc = '0;
        t_mat = '{default: '0};
        for (int u = 0; u < BLK; u++) begin
            for (int m = 0; m < BLK; m++) begin
                t_acc = '0;
                for (int n = 0; n < BLK; n++) begin
                    t_acc = t_acc + 32'(DCT_C[u][n]) * 32'(pix[n*BLK+m]);
                end
                t_mat[u][m] = t_acc;
            end
        end
    end

    // Row pass: Y = T * C^T
    always_comb begin
        y_acc = '0;
        y_mat = '{default: '0};
        for (int u = 0; u < BLK; u++) begin
            for (int v = 0; v < BLK; v++) begin
                y_acc = '0;
                for (int m = 0; m < BLK; m++) begin
                    y_acc = y_acc + COEFF_W'(t_mat[u][m]) * COEFF_W'(DCT_C[v][m]);
                end
                y_mat[u][v] = y_acc;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity for negative terms.
    always_comb begin
        coeff = '{default: '0};
        for (int u = 0; u < BLK; u++) begin
            for (int v = 0; v < BLK; v++) begin
                coeff[u*BLK+v] = y_mat[u][v] >>> (BASE_SHIFT + QSHIFT[u][v]);
            end
        end
    end

endmodule

// File: rtl/compressor_seq_top.sv
// compressor_seq_top: walks a full frame in 8x8 blocks, NUM_LANES horizontally
// adjacent blocks per cycle, and writes quantized DCT coefficients into a
// full-frame output array.
//   clk                  : rising-edge clock
//   rst_n                : synchronous active-low reset (clears outputs, aborts a frame)
//   start_img            : start pulse; honoured in IDLE and DONE, ignored in RUN
//   image                : pixel frame, held stable from start_img until img_done
//   quantized_coeffs_out : coefficient (u,v) of block (br,bc) lands at [8br+u][8bc+v]
//   img_done             : level-high once the last block pair has been written
// Pipeline: a block pair is read into blk_q on one edge, transformed
// combinationally, and written to the output array on the following edge.
// img_done therefore rises (blocks / NUM_LANES) + 1 edges after the start edge.
module compressor_seq_top
    import codec_pkg::*;
#(
    parameter int IMG_H     = IMG_H_DEF,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int NUM_LANES = 2,
    parameter int OUT_W     = COEFF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_img,
    input  logic signed [PIX_W-1:0] image                [IMG_H][IMG_W],
    output logic signed [OUT_W-1:0] quantized_coeffs_out [IMG_H][IMG_W],
    output logic                    img_done
);

    localparam int BROWS  = IMG_H / BLK;
    localparam int BPAIRS = IMG_W / (BLK * NUM_LANES);
    localparam int BR_W   = (BROWS  > 1) ? $clog2(BROWS)  : 1;
    localparam int BP_W   = (BPAIRS > 1) ? $clog2(BPAIRS) : 1;
    localparam logic [BR_W-1:0] BR_LAST = BR_W'(BROWS - 1);
    localparam logic [BP_W-1:0] BP_LAST = BP_W'(BPAIRS - 1);

    state_t state, state_next;

    logic [BR_W-1:0] br;
    logic [BP_W-1:0] bp;
    logic            issue_end;   // last pair has been read; stop issuing
    logic            issue;
    logic            restart;
    logic            last_pair;

    logic signed [PIX_W-1:0]   gather     [NUM_LANES][BLK_PIX];
    logic signed [PIX_W-1:0]   blk_q      [NUM_LANES][BLK_PIX];
    logic                      blk_valid;
    logic                      blk_last;
    logic [BR_W-1:0]           blk_br;
    logic [BP_W-1:0]           blk_bp;
    logic signed [COEFF_W-1:0] lane_coeff [NUM_LANES][BLK_PIX];

    assign last_pair = (br == BR_LAST) && (bp == BP_LAST);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. RUN ends when the final pair is written, not read.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_img)              state_next = ST_RUN;
            ST_RUN:  if (blk_valid && blk_last)  state_next = ST_DONE;
            ST_DONE: if (start_img)              state_next = ST_RUN;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        img_done = (state == ST_DONE);
        issue    = (state == ST_RUN) && !issue_end;
        restart  = start_img && (state != ST_RUN);
    end

    // Block gather: lane l reads block column NUM_LANES*bp + l of block row br.
    always_comb begin
        gather = '{default: '0};
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < BLK; r++) begin
                for (int c = 0; c < BLK; c++) begin
                    gather[l][r*BLK+c] =
                        image[BLK*int'(br)+r][BLK*(NUM_LANES*int'(bp)+l)+c];
                end
            end
        end
    end

    // Counters and the read stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br        <= '0;
            bp        <= '0;
            issue_end <= 1'b0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            blk_br    <= '0;
            blk_bp    <= '0;
        end else if (restart) begin
            br        <= '0;
            bp        <= '0;
            issue_end <= 1'b0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else if (issue) begin
            blk_q     <= gather;
            blk_valid <= 1'b1;
            blk_last  <= last_pair;
            blk_br    <= br;
            blk_bp    <= bp;
            if (last_pair) begin
                issue_end <= 1'b1;
            end else if (bp == BP_LAST) begin
                bp <= '0;
                br <= br + BR_W'(1);
            end else begin
                bp <= bp + BP_W'(1);
            end
        end else begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dct8x8_quant u_dct (
            .pix   (blk_q[l]),
            .coeff (lane_coeff[l])
        );
    end

    // Scatter: only the pair in flight is written; all other entries hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < IMG_H; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    quantized_coeffs_out[r][c] <= '0;
                end
            end
        end else if (blk_valid) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int u = 0; u < BLK; u++) begin
                    for (int v = 0; v < BLK; v++) begin
                        quantized_coeffs_out[BLK*int'(blk_br)+u][BLK*(NUM_LANES*int'(blk_bp)+l)+v]
                            <= OUT_W'(lane_coeff[l][u*BLK+v]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_compressor_seq_top.sv
// tb_compressor_seq_top: directed frames with hand-computed expectations.
// The driver loads a frame, pulses start_img and pushes the expected result
// into exp_q; the monitor pops and checks whenever img_done rises.
module tb_compressor_seq_top;

    localparam int H     = 480;
    localparam int W     = 640;
    localparam int LANES = 2;
    localparam int OW    = 54;
    localparam int LAT   = (H/8) * (W/8) / LANES + 1;   // 2401

    localparam int K_CONST   = 0;
    localparam int K_IMPULSE = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start_img;
    logic img_done;
    logic signed [8:0]    image [H][W];
    logic signed [OW-1:0] q_out [H][W];

    typedef struct {
        int     kind;
        longint dc;
        longint start_edge;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint cmat   [8][8];
    longint golden [8][8];
    logic   done_prev = 1'b0;

    compressor_seq_top #(
        .IMG_H     (H),
        .IMG_W     (W),
        .NUM_LANES (LANES),
        .OUT_W     (OW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_img            (start_img),
        .image                (image),
        .quantized_coeffs_out (q_out),
        .img_done             (img_done)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic longint out_at(input int r, input int c);
        return longint'(q_out[r][c]);
    endfunction

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        int     bad = 0;
        longint first = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (out_at(r, c) != 0) begin
                    if (bad == 0) first = out_at(r, c);
                    bad++;
                end
        check_eq($sformatf("%s_nonzero_entries(first %0d)", tag, first), bad, 0);
    endtask

    // DC of every block must equal dc, every AC entry must be 0.
    task automatic check_const_frame(input string tag, input longint dc);
        int     bad_dc = 0, bad_ac = 0;
        longint f_dc = 0, f_ac = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if ((r % 8 == 0) && (c % 8 == 0)) begin
                    if (out_at(r, c) != dc) begin
                        if (bad_dc == 0) f_dc = out_at(r, c);
                        bad_dc++;
                    end
                end else if (out_at(r, c) != 0) begin
                    if (bad_ac == 0) f_ac = out_at(r, c);
                    bad_ac++;
                end
            end
        check_eq($sformatf("%s_dc_bad_blocks(first got %0d want %0d)", tag, f_dc, dc), bad_dc, 0);
        check_eq($sformatf("%s_ac_bad_entries(first got %0d)", tag, f_ac), bad_ac, 0);
    endtask

    task automatic check_impulse_frame();
        int     bad_blk = 0, bad_rest = 0;
        longint f_blk = 0;
        check_eq("impulse_dc", out_at(0, 0), 1);
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                if (out_at(u, v) != golden[u][v]) begin
                    if (bad_blk == 0) f_blk = out_at(u, v);
                    bad_blk++;
                end
        check_eq($sformatf("impulse_golden_bad(first got %0d)", f_blk), bad_blk, 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if ((r >= 8 || c >= 8) && out_at(r, c) != 0) bad_rest++;
        check_eq("impulse_other_blocks_nonzero", bad_rest, 0);
    endtask

    // Golden model: real-valued basis, rounded half away from zero,
    // then the full quadruple sum sum_n sum_m C[u][n] X[n][m] C[v][m].
    task automatic build_golden();
        real    ck, x;
        longint blk [8][8];
        longint y;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
            for (int n = 0; n < 8; n++) begin
                x = 4096.0 * ck * $cos((2.0*n + 1.0) * k * 3.14159265358979323846 / 16.0);
                cmat[k][n] = (x >= 0.0) ? longint'($floor(x + 0.5)) : -longint'($floor(-x + 0.5));
            end
        end
        for (int n = 0; n < 8; n++)
            for (int m = 0; m < 8; m++)
                blk[n][m] = 0;
        blk[0][0] = 255;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                y = 0;
                for (int n = 0; n < 8; n++)
                    for (int m = 0; m < 8; m++)
                        y += cmat[u][n] * blk[n][m] * cmat[v][m];
                golden[u][v] = y >>> (24 + 4 + ((u + v) >> 1));
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                image[r][c] = 9'(v);
    endtask

    task automatic fill_impulse();
        fill_const(0);
        image[0][0] = 9'sd255;
    endtask

    task automatic start_frame(input int kind, input longint dc, input int hold, input bit push);
        exp_t e;
        @(negedge clk);
        start_img    = 1'b1;
        e.kind       = kind;
        e.dc         = dc;
        e.start_edge = cyc + 1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        check_eq("done_low_after_start", img_done, 0);
        repeat (hold - 1) @(negedge clk);
        start_img = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!img_done && n < LAT + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("%s_done_within_budget", tag), img_done, 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (img_done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", img_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("done_latency", cyc - e.start_edge, LAT);
                    if (e.kind == K_IMPULSE) check_impulse_frame();
                    else                     check_const_frame($sformatf("const_dc%0d", e.dc), e.dc);
                end
            end
            done_prev = img_done;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        rst_n     = 1'b0;
        start_img = 1'b0;
        fill_const(0);
        build_golden();

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_img_done", img_done, 0);
        rst_n = 1'b1;

        // All-zero frame from IDLE.
        start_frame(K_CONST, 0, 1, 1'b1);
        wait_done("zero");

        // Constant +100: DC = 13418905600 >>> 28 = 49.
        fill_const(100);
        start_frame(K_CONST, 49, 1, 1'b1);
        wait_done("pos100");

        // Constant -100 with start_img held well into RUN: DC = -50.
        fill_const(-100);
        start_frame(K_CONST, -50, 20, 1'b1);
        wait_done("neg100");

        // Single impulse in block (0,0).
        fill_impulse();
        start_frame(K_IMPULSE, 1, 1, 1'b1);
        wait_done("impulse");

        // Mid-frame abort roughly 1000 cycles into a +100 frame.
        fill_const(100);
        start_frame(K_CONST, 49, 1, 1'b0);
        repeat (998) @(negedge clk);
        check_eq("abort_first_block_written", out_at(0, 0), 49);
        check_eq("abort_last_block_untouched", out_at(H-8, W-8), 0);
        check_eq("abort_done_low_mid_run", img_done, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("abort_reset");
        check_eq("abort_reset_img_done", img_done, 0);
        seen = 0;
        repeat (LAT + 200) begin
            @(negedge clk);
            if (img_done) seen++;
        end
        check_eq("abort_no_done_cycles", seen, 0);

        check_eq("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
